// File: rtl/dpram_sclk.sv
// Simple dual-port RAM on a single clock: one write port, one registered
// read port with write-first bypass when both ports hit the same address.
// The storage array is never reset so it can map onto block RAM; only the
// read register is cleared by the asynchronous active-low reset.
module dpram_sclk #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   localparam int Depth = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [DATA_WIDTH-1:0] dout_q;
   logic [DATA_WIDTH-1:0] dout_d;
   logic                  collide;

   assign collide = we && (waddr == raddr);

   // Write port: one word per edge, blocked while reset is held low.
   always_ff @(posedge clk) begin
      if (rst && we) begin
         mem_q[waddr] <= din;
      end
   end

   // Next read value: hold when idle, forward din when a write hits the same word.
   always_comb begin
      dout_d = dout_q;
      if (re) begin
         if (collide) begin
            dout_d = din;
         end else begin
            dout_d = mem_q[raddr];
         end
      end
   end

   // Read register: cleared asynchronously, otherwise loads the selected word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_dpram_sclk.sv
// Randomised and directed bench for dpram_sclk, checked against an
// array-based reference memory kept in the bench.
module tb_dpram_sclk;

   logic        clk;
   logic        rst;
   logic        we;
   logic        re;
   logic [8:0]  waddr;
   logic [8:0]  raddr;
   logic [15:0] din;
   logic [15:0] dout;

   // Reference model state
   logic [15:0] refMem [512];
   bit          refWritten [512];
   logic [15:0] expDout;
   bit          expKnown;

   int checks;
   int fails;

   dpram_sclk #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .re    (re),
      .waddr (waddr),
      .raddr (raddr),
      .din   (din),
      .dout  (dout)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive on the falling edge, update the model on the
   // rising edge, then compare shortly after it.
   task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                input logic [8:0] wa, input logic [8:0] ra,
                                input logic [15:0] d, input string tag);
      @(negedge clk);
      rst   = r;
      we    = w;
      re    = rd;
      waddr = wa;
      raddr = ra;
      din   = d;
      if (!r) begin
         #1;
         checkOutput({tag, "_async_rst"}, dout, 16'h0000);
      end
      @(posedge clk);
      if (!r) begin
         expDout  = 16'h0000;
         expKnown = 1'b1;
      end else begin
         if (rd) begin
            if (w && wa == ra) begin
               expDout  = d;
               expKnown = 1'b1;
            end else begin
               expDout  = refMem[ra];
               expKnown = refWritten[ra];
            end
         end
         if (w) begin
            refMem[wa]     = d;
            refWritten[wa] = 1'b1;
         end
      end
      #1;
      if (expKnown) begin
         checkOutput(tag, dout, expDout);
      end
   endtask

   initial begin
      checks   = 0;
      fails    = 0;
      expDout  = 16'h0000;
      expKnown = 1'b1;
      for (int i = 0; i < 512; i++) begin
         refWritten[i] = 1'b0;
         refMem[i]     = 16'h0000;
      end
      rst   = 1'b0;
      we    = 1'b0;
      re    = 1'b0;
      waddr = '0;
      raddr = '0;
      din   = '0;

      #2;
      checkOutput("reset_state", dout, 16'h0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0, "init_rst");

      // Sequential fill: address i holds value i.
      for (int i = 1; i <= 150; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 9'(i), 9'd0, 16'(i), "seq_wr");
      end

      // Reset held with both enables on: no writes, dout pinned to zero.
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 9'(i), 9'(i), 16'($urandom), "rst_hold");
      end

      // Read back the fill; the reset above must not have disturbed it.
      for (int i = 1; i <= 150; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'(i), 16'h0, "seq_rd");
         checkOutput("seq_rd_value", dout, 16'(i));
      end

      // Streaming: read trails write by one address.
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b1, i > 0, 9'(200 + i), 9'(200 + i - 1),
                       16'($urandom), "stream");
      end

      // Same-address collision returns new data, and memory keeps it.
      applyStimulus(1'b1, 1'b1, 1'b1, 9'd5, 9'd5, 16'hABCD, "collide");
      checkOutput("collide_value", dout, 16'hABCD);
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'd9, 16'h0, "collide_other");
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'd5, 16'h0, "collide_reread");
      checkOutput("collide_reread_value", dout, 16'hABCD);

      // Hold: dout keeps 0x0007 while re is low and everything else moves.
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'd7, 16'h0, "hold_load");
      checkOutput("hold_load_value", dout, 16'h0007);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 9'(300 + i), 9'(i * 37), 16'($urandom), "hold");
         checkOutput("hold_value", dout, 16'h0007);
      end

      // Boundary addresses survive a one-cycle reset pulse.
      applyStimulus(1'b1, 1'b1, 1'b0, 9'd511, 9'd0, 16'hFFFF, "bnd_wr_hi");
      applyStimulus(1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 16'h1234, "bnd_wr_lo");
      applyStimulus(1'b0, 1'b1, 1'b1, 9'd0, 9'd511, 16'h5555, "bnd_rst");
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'd511, 16'h0, "bnd_rd_hi");
      checkOutput("bnd_rd_hi_value", dout, 16'hFFFF);
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd0, 9'd0, 16'h0, "bnd_rd_lo");
      checkOutput("bnd_rd_lo_value", dout, 16'h1234);

      // Random traffic on a narrow address window to provoke collisions.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 24) != 0), 1'($urandom), 1'($urandom),
                       9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
                       16'($urandom), "random");
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/dpram_sclk.md
DPRAM_SCLK -- requirements
Module: dpram_sclk

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of each stored word and of din/dout.
REQ-002 Parameter ADDR_WIDTH, default 9: address width; depth = 2**ADDR_WIDTH = 512 words.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge, except reset assertion.
REQ-004 Port rst, input, 1: asynchronous active-low reset (0 = reset asserted).
REQ-005 Port we, input, 1: write enable; active-high.
REQ-006 Port re, input, 1: read enable; active-high.
REQ-007 Port waddr, input, ADDR_WIDTH: write address.
REQ-008 Port raddr, input, ADDR_WIDTH: read address.
REQ-009 Port din, input, DATA_WIDTH: write data.
REQ-010 Port dout, output, DATA_WIDTH: registered read data.

Function
REQ-011 The block SHALL be a simple dual-port RAM: one write port and one read port, both independent and both clocked by clk.
REQ-012 On a rising clk edge with rst=1 and we=1, the block SHALL store din at mem[waddr].
REQ-013 When we=0, memory contents SHALL NOT change.
REQ-014 On a rising clk edge with rst=1 and re=1, dout SHALL load mem[raddr]; read latency is exactly 1 cycle from address/enable sampling to dout.
REQ-015 When re=0, dout SHALL hold its previous value.
REQ-016 Read and write in the same cycle to different addresses SHALL both complete with no interaction.
REQ-017 Read and write in the same cycle to the same address: dout SHALL return the new din (write-first bypass); the memory SHALL also store din.
REQ-018 A write followed by a read of that address in the next cycle SHALL return the written data.
REQ-019 Addresses SHALL cover the full range 0..511; there is no out-of-range case and no wrap logic inside the block.
REQ-020 Signals we, re, waddr, raddr and din SHALL be sampled only at rising clk edges; there are no combinational paths from inputs to dout.
REQ-021 Memory SHALL be inferable as block RAM: no reset of the storage array and no multi-word writes per cycle.

Reset
REQ-022 While rst=0, dout SHALL be 0 immediately (asynchronous), independent of clk.
REQ-023 While rst=0, writes SHALL be suppressed and dout SHALL stay 0 regardless of we/re.
REQ-024 Memory contents SHALL be unaffected by reset: data written before reset assertion remains readable after release; never-written locations are undefined (X in simulation).
REQ-025 After rst returns to 1, the first rising edge SHALL perform normal write/read operations.
REQ-026 Reset asserted mid-operation SHALL abort only the dout update in progress; any write completed on a prior edge is retained.

Verification
REQ-027 Reset: hold rst=0 for 10 cycles with we=re=1 -> dout=0 throughout; mem unchanged.
REQ-028 Sequential write: we=1 for 150 cycles, waddr=din=1,2,3,...; then re=1 with raddr=1..150 -> dout equals raddr one cycle after each read.
REQ-029 Streaming: write address/data increments each cycle; read enabled one cycle later with raddr trailing by one -> dout equals the value written the previous cycle; no X after the pipeline fills.
REQ-030 Collision: we=re=1, waddr=raddr=5, din=16'hABCD -> dout=16'hABCD on the next cycle; a later read of address 5 also returns 16'hABCD.
REQ-031 Hold: after dout=16'h0007, deassert re while changing raddr and continuing writes -> dout stays 16'h0007.
REQ-032 Boundary/retention: write 16'hFFFF at address 511 and 16'h1234 at 0, pulse rst=0 for 1 cycle, then read 511 and 0 -> dout=16'hFFFF then 16'h1234.
